// File: rtl/sparse_buffer_rd_arb_if.sv
// Purpose: requester, response and sparse-buffer read-port signals of the
//          sparse buffer read arbiter, bundled as one interface.
// Ports (by group):
//   requesters : req_valid_i, req_ptr_i -> req_ready_o
//   response   : rsp_valid_o, rsp_id_o, rsp_data_o <- rsp_ready_i
//   status     : err_timeout_o
//   buffer     : sb_valid_i, sb_read_allowIn_i, sb_read_rtn_valid_i,
//                sb_read_rtn_data_i -> sb_read_valid_o, sb_read_ptr_o,
//                sb_read_rtn_allowIn_o
// Modports: slave = arbiter side, master = requesters/consumer/buffer side.
interface sparse_buffer_rd_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned SIZE = 8
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*AW-1:0] req_ptr_i;
    logic [NREQ-1:0]    req_ready_o;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [IDW-1:0]     rsp_id_o;
    logic [DW-1:0]      rsp_data_o;
    logic [NREQ-1:0]    err_timeout_o;
    logic [SIZE-1:0]    sb_valid_i;
    logic               sb_read_valid_o;
    logic [AW-1:0]      sb_read_ptr_o;
    logic               sb_read_allowIn_i;
    logic               sb_read_rtn_allowIn_o;
    logic               sb_read_rtn_valid_i;
    logic [DW-1:0]      sb_read_rtn_data_i;

    modport slave (
        input  req_valid_i, req_ptr_i, rsp_ready_i, sb_valid_i,
               sb_read_allowIn_i, sb_read_rtn_valid_i, sb_read_rtn_data_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, err_timeout_o,
               sb_read_valid_o, sb_read_ptr_o, sb_read_rtn_allowIn_o
    );

    modport master (
        output req_valid_i, req_ptr_i, rsp_ready_i, sb_valid_i,
               sb_read_allowIn_i, sb_read_rtn_valid_i, sb_read_rtn_data_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, err_timeout_o,
               sb_read_valid_o, sb_read_ptr_o, sb_read_rtn_allowIn_o
    );
endinterface

// File: rtl/sparse_buffer_rd_arb.sv
// Purpose: round-robin read arbiter for the 8-entry sparse buffer. Grants one
//          requester per cycle whose target entry is valid, captures the read
//          data in a one-deep response register, and flags requesters that
//          starve on an invalid entry.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : sparse_buffer_rd_arb_if.slave (requests, response, timeout flags,
//           buffer read port)
module sparse_buffer_rd_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned SIZE = 8,
    parameter int unsigned TOW  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sparse_buffer_rd_arb_if.slave bus
);
    localparam int unsigned    IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TOW-1:0] CNT_MAX = '1;

    logic [NREQ-1:0] elig_c;
    logic            slot_free_c;
    logic            grant_en_c;
    logic            grant_any_c;
    logic [IDW-1:0]  win_c;
    logic [NREQ-1:0] grant_c;
    logic [AW-1:0]   win_ptr_c;
    int unsigned     cand_c;

    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [DW-1:0]   rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]  last_q,      last_d;
    logic [TOW-1:0]  cnt_q [NREQ];
    logic [TOW-1:0]  cnt_d [NREQ];
    logic [NREQ-1:0] err_q,       err_d;

    // Requester is eligible only while its target entry holds valid data
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_c[i] = bus.req_valid_i[i] & bus.sb_valid_i[bus.req_ptr_i[i*AW +: AW]];
        end
    end

    // Round-robin pick: first eligible index after last_q, wrapping
    always_comb begin
        slot_free_c = ~rsp_valid_q | bus.rsp_ready_i;
        grant_en_c  = slot_free_c & bus.sb_read_allowIn_i & ~rst_i;
        grant_any_c = 1'b0;
        win_c       = '0;
        cand_c      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = (32'(last_q) + k) % NREQ;
            if (grant_en_c && !grant_any_c && elig_c[IDW'(cand_c)]) begin
                grant_any_c = 1'b1;
                win_c       = IDW'(cand_c);
            end
        end
    end

    // One-hot grant; winner pointer by OR over the one-hot mask (0 when idle)
    always_comb begin
        grant_c   = grant_any_c ? (NREQ'(1) << win_c) : '0;
        win_ptr_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                win_ptr_c = win_ptr_c | bus.req_ptr_i[i*AW +: AW];
            end
        end
    end

    // Response register and round-robin pointer next state; a grant in the
    // drain cycle overwrites the register so back-to-back reads are possible
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
        if (grant_any_c) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_c;
            rsp_data_d  = bus.sb_read_rtn_data_i;
            last_d      = win_c;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Starvation counters; the flag is raised in the cycle the count saturates
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant_c[i] || !bus.req_valid_i[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + TOW'(1);
            end
            if (grant_c[i]) begin
                err_d[i] = 1'b0;
            end else if (cnt_d[i] == CNT_MAX) begin
                err_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            last_q      <= IDW'(NREQ - 1);
            err_q       <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
            err_q       <= err_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.req_ready_o           = grant_c;
    assign bus.sb_read_valid_o       = grant_any_c;
    assign bus.sb_read_rtn_allowIn_o = grant_any_c;
    assign bus.sb_read_ptr_o         = win_ptr_c;
    assign bus.rsp_valid_o           = rsp_valid_q;
    assign bus.rsp_id_o              = rsp_id_q;
    assign bus.rsp_data_o            = rsp_data_q;
    assign bus.err_timeout_o         = err_q;
endmodule

// File: tb/tb_sparse_buffer_rd_arb.sv
// Purpose: directed scoreboard bench for sparse_buffer_rd_arb with a
//          behavioural 8-entry sparse buffer (write port + combinational read).
module tb_sparse_buffer_rd_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned SIZE = 8;
    localparam int unsigned TOW  = 6;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_v     = '0;
    logic [NREQ*AW-1:0] req_p     = '0;
    logic               rsp_ready = 1'b1;
    logic               allow_in  = 1'b1;
    logic               wr_en     = 1'b0;
    logic [AW-1:0]      wr_ptr    = '0;
    logic [DW-1:0]      wr_data   = '0;
    logic [SIZE-1:0]    sbv       = '0;
    logic [DW-1:0]      mem [SIZE];

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q [$];
    rsp_t mon_e;

    sparse_buffer_rd_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW), .SIZE(SIZE)) bus ();

    sparse_buffer_rd_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .SIZE(SIZE), .TOW(TOW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.req_valid_i         = req_v;
    assign bus.req_ptr_i           = req_p;
    assign bus.rsp_ready_i         = rsp_ready;
    assign bus.sb_read_allowIn_i   = allow_in;
    assign bus.sb_valid_i          = sbv;
    assign bus.sb_read_rtn_data_i  = mem[bus.sb_read_ptr_o];
    assign bus.sb_read_rtn_valid_i = bus.sb_read_valid_o & sbv[bus.sb_read_ptr_o];

    // Buffer model: a read clears the entry, a write in the same cycle wins
    always @(posedge clk) begin
        if (bus.sb_read_valid_o) sbv[bus.sb_read_ptr_o] <= 1'b0;
        if (wr_en) begin
            sbv[wr_ptr] <= 1'b1;
            mem[wr_ptr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_ptr_hold
        a_ptr_hold: assert property (@(posedge clk) disable iff (rst)
            (req_v[g] && !bus.req_ready_o[g]) |=> (!req_v[g] || $stable(req_p[g*AW +: AW])))
            else $error("requester %0d changed pointer while waiting", g);
    end

    a_rtn_valid: assert property (@(posedge clk) disable iff (rst)
        bus.sb_read_valid_o |-> bus.sb_read_rtn_valid_i)
        else $error("read issued to an invalid entry");

    // Response monitor: every accepted response must match the next expectation
    always begin
        @(negedge clk);
        #4;
        if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h, none expected",
                         bus.rsp_id_o, bus.rsp_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rsp_id_o !== mon_e.id || bus.rsp_data_o !== mon_e.data) begin
                    errors++;
                    $display("FAIL rsp_match: got id=%0d data=0x%0h, expected id=%0d data=0x%0h",
                             bus.rsp_id_o, bus.rsp_data_o, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic buf_write(input int p, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_ptr  = AW'(p);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic set_ptr(input int i, input int p);
        req_p[i*AW +: AW] = AW'(p);
    endtask

    task automatic push(input int id, input logic [7:0] d);
        rsp_t e;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    logic [7:0] rr_data [4] = '{8'h10, 8'h11, 8'h12, 8'h16};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("reset_rsp_id", 32'(bus.rsp_id_o), 0);
        chk("reset_rsp_data", 32'(bus.rsp_data_o), 0);
        chk("reset_err", 32'(bus.err_timeout_o), 0);

        // Single read of entry 3
        buf_write(3, 8'hA5);
        set_ptr(0, 3);
        req_v = 4'b0001;
        #1;
        chk("single_ready", 32'(bus.req_ready_o), 32'h1);
        chk("single_ptr", 32'(bus.sb_read_ptr_o), 3);
        chk("single_rd_valid", 32'(bus.sb_read_valid_o), 1);
        push(0, 8'hA5);
        @(negedge clk);
        req_v = '0;
        #1;
        chk("single_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("single_rsp_id", 32'(bus.rsp_id_o), 0);
        chk("single_rsp_data", 32'(bus.rsp_data_o), 32'hA5);

        // Held response dropped by reset; round-robin pointer restored
        buf_write(7, 8'h77);
        rsp_ready = 1'b0;
        set_ptr(1, 7);
        req_v = 4'b0010;
        #1;
        chk("prerst_ready", 32'(bus.req_ready_o), 32'h2);
        @(negedge clk);
        req_v = '0;
        #1;
        chk("prerst_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("prerst_rsp_data", 32'(bus.rsp_data_o), 32'h77);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("midrst_rsp_data", 32'(bus.rsp_data_o), 0);

        // Round robin over four distinct entries
        buf_write(0, 8'h10);
        buf_write(1, 8'h11);
        buf_write(2, 8'h12);
        buf_write(6, 8'h16);
        set_ptr(0, 0); set_ptr(1, 1); set_ptr(2, 2); set_ptr(3, 6);
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", 32'(bus.req_ready_o), 32'(1 << i));
            push(i, rr_data[i]);
            @(negedge clk);
            req_v[i] = 1'b0;
        end
        buf_write(1, 8'h21);
        buf_write(2, 8'h22);
        req_v = 4'b0110;
        #1;
        chk("rr2_grant_1", 32'(bus.req_ready_o), 32'h2);
        push(1, 8'h21);
        @(negedge clk);
        req_v = 4'b0100;
        #1;
        chk("rr2_grant_2", 32'(bus.req_ready_o), 32'h4);
        push(2, 8'h22);
        @(negedge clk);
        req_v = '0;

        // Back-pressure holds the response and blocks grants
        buf_write(0, 8'h30);
        buf_write(1, 8'h31);
        set_ptr(0, 0); set_ptr(1, 1);
        req_v = 4'b0011;
        #1;
        chk("bp_first_grant", 32'(bus.req_ready_o), 32'h1);
        push(0, 8'h30);
        @(negedge clk);
        req_v = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("bp_ready_blocked", 32'(bus.req_ready_o), 0);
        chk("bp_rd_blocked", 32'(bus.sb_read_valid_o), 0);
        @(negedge clk);
        #1;
        chk("bp_data_held", 32'(bus.rsp_data_o), 32'h30);
        chk("bp_ready_blocked2", 32'(bus.req_ready_o), 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_resume_grant", 32'(bus.req_ready_o), 32'h2);
        push(1, 8'h31);
        @(negedge clk);
        req_v = '0;

        // Starvation on invalid entry 5
        set_ptr(2, 5);
        req_v = 4'b0100;
        #1;
        chk("to_no_grant", 32'(bus.req_ready_o), 0);
        repeat (62) @(negedge clk);
        #1;
        chk("to_err_before", 32'(bus.err_timeout_o), 0);
        @(negedge clk);
        #1;
        chk("to_err_set", 32'(bus.err_timeout_o), 32'h4);
        repeat (3) @(negedge clk);
        #1;
        chk("to_err_sticky", 32'(bus.err_timeout_o), 32'h4);
        buf_write(5, 8'h55);
        #1;
        chk("to_grant", 32'(bus.req_ready_o), 32'h4);
        push(2, 8'h55);
        @(negedge clk);
        req_v = '0;
        #1;
        chk("to_err_cleared", 32'(bus.err_timeout_o), 0);

        // Two requesters on the same entry
        buf_write(4, 8'h44);
        set_ptr(0, 4); set_ptr(1, 4);
        req_v = 4'b0011;
        #1;
        chk("same_grant0", 32'(bus.req_ready_o), 32'h1);
        push(0, 8'h44);
        @(negedge clk);
        req_v = 4'b0010;
        #1;
        chk("same_wait1", 32'(bus.req_ready_o), 0);
        @(negedge clk);
        #1;
        chk("same_wait2", 32'(bus.req_ready_o), 0);
        buf_write(4, 8'h45);
        #1;
        chk("same_grant1", 32'(bus.req_ready_o), 32'h2);
        push(1, 8'h45);
        @(negedge clk);
        req_v = '0;

        // Buffer refuses reads
        buf_write(6, 8'h66);
        allow_in = 1'b0;
        set_ptr(3, 6);
        req_v = 4'b1000;
        #1;
        chk("allow_ready_low", 32'(bus.req_ready_o), 0);
        chk("allow_rd_low", 32'(bus.sb_read_valid_o), 0);
        @(negedge clk);
        #1;
        chk("allow_ready_low2", 32'(bus.req_ready_o), 0);
        @(negedge clk);
        allow_in = 1'b1;
        #1;
        chk("allow_grant", 32'(bus.req_ready_o), 32'h8);
        chk("allow_ptr", 32'(bus.sb_read_ptr_o), 6);
        push(3, 8'h66);
        @(negedge clk);
        req_v = '0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sparse_buffer_rd_arb.md
# sparse_buffer_rd_arb

Read-side arbiter/scheduler for the 8-entry sparse buffer. Shares the buffer's single read port among NREQ requesters, each naming the entry pointer it wants. Only entries currently marked valid are granted, with round-robin fairness. Each read result is captured in a one-deep response register, and requesters left waiting on an invalid entry are flagged by a per-requester timeout.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: data width; matches the sparse buffer
- AW, 3: pointer width
- SIZE, 8: buffer entries (2**AW)
- TOW, 6: timeout counter width; timeout fires at count 2**TOW-1

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NREQ  per-requester read request
- req_ptr_i  in  NREQ*AW  requester i pointer at bits [i*AW +: AW]
- req_ready_o  out  NREQ  one-hot grant; request i accepted when req_valid_i[i] & req_ready_o[i]
- rsp_valid_o  out  1  response register holds data
- rsp_ready_i  in  1  consumer accepts the response
- rsp_id_o  out  $clog2(NREQ)  requester index of the held response
- rsp_data_o  out  DW  data read from the buffer
- err_timeout_o  out  NREQ  sticky per-requester starvation flag
- sb_valid_i  in  SIZE  buffer entry valid vector
- sb_read_valid_o  out  1  buffer read request
- sb_read_ptr_o  out  AW  buffer read pointer
- sb_read_allowIn_i  in  1  buffer read acceptance; must be high for a grant
- sb_read_rtn_allowIn_o  out  1  return-path acceptance to the buffer
- sb_read_rtn_valid_i  in  1  combinational return valid from the buffer
- sb_read_rtn_data_i  in  DW  combinational return data from the buffer

## Operation
- Eligibility: requester i is eligible when req_valid_i[i] and sb_valid_i[req_ptr_i[i]] are both 1.
- Slot free: slot_free = ~rsp_valid_o | rsp_ready_i.
- Grant: when slot_free is 1, at least one requester is eligible, and sb_read_allowIn_i is 1, the arbiter grants exactly one requester. The winner is the first eligible index searching upward, wrapping, from last_grant+1.
- Buffer drive:
  - sb_read_valid_o = sb_read_rtn_allowIn_o = grant_any.
  - sb_read_ptr_o = the winner's pointer; 0 when there is no grant.
  - The buffer clears the entry's valid bit at the clock edge.
- Capture: on a grant, the response register loads sb_read_rtn_data_i and the winner's index, and sets rsp_valid_o.
  - If sb_read_rtn_valid_i is 0 at grant, it is a protocol violation. The data is still captured; no other action is taken.
- Drain: rsp_valid_o falls when rsp_ready_i is 1 and there is no simultaneous grant. A simultaneous drain and grant overwrites the register, so full throughput is one read per cycle.
- last_grant updates only on a grant. Its reset value is NREQ-1, so requester 0 has first priority.
- Same pointer from several requesters: only the winner is served. The others become ineligible next cycle because the entry is now invalid, and they wait until the entry is rewritten.
- Timeout:
  - Per-requester counter increments each cycle req_valid_i[i] is 1 and i is not granted.
  - It clears when req_valid_i[i] is 0 or when i is granted.
  - It saturates at 2**TOW-1; at saturation it sets err_timeout_o[i].
  - err_timeout_o[i] clears only on reset or a grant to i.
- A requester may not change req_ptr_i while req_valid_i is 1 and not yet granted. This rule is checked by assertion in the bench, not by the RTL.

## Timing
- Reset values: rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, err_timeout_o=0, all counters 0, last_grant=NREQ-1.
- req_ready_o, sb_read_valid_o and sb_read_ptr_o are combinational from the current inputs and state, and are 0 during reset.
- Latency: request accepted in cycle N gives rsp_valid_o=1 in cycle N+1.
- Back-pressure: while rsp_valid_o=1 and rsp_ready_i=0, no grant is made and all req_ready_o are 0.
- Reset asserted mid-operation: the held response is dropped and round-robin state is restored. The buffer's own valid bits are outside this block.
- Timeout detection: a requester continuously valid and never granted from cycle N has err_timeout_o=1 in cycle N+2**TOW-1.

## Test plan
- Single read, entry 3 valid with data 0xA5:
  - Stimulus: req 0 with ptr 3.
  - Required: req_ready_o=0001 in cycle N, sb_read_ptr_o=3; in N+1 rsp_valid_o=1, rsp_id_o=0, rsp_data_o=0xA5.
- Round-robin fairness, all 4 requesters valid on distinct valid entries, rsp_ready_i=1:
  - Required: grants in order 0,1,2,3, one per cycle.
  - Then, with req 1 and req 2 re-requesting valid entries, grant order is 1,2.
- Back-pressure:
  - Stimulus: rsp_ready_i=0 after the first response.
  - Required: no further grant, rsp_data_o held; raising rsp_ready_i resumes with a grant the same cycle.
- Invalid entry:
  - Stimulus: req 2 on ptr 5 with sb_valid_i[5]=0.
  - Required: no grant; with TOW=6, err_timeout_o[2]=1 after 63 cycles; setting sb_valid_i[5]=1 yields a grant and the flag clears.
- Same-pointer contention:
  - Stimulus: req 0 and req 1 both on ptr 4 (valid).
  - Required: only req 0 is granted; req 1 waits until entry 4 is revalidated.
- sb_read_allowIn_i=0:
  - Stimulus: eligible requests present.
  - Required: req_ready_o=0 and sb_read_valid_o=0; when allowIn rises, the grant proceeds.
